// File: rtl/ahb_bus_arbiter.sv
// Round-robin, burst-aware AHB arbiter. Grants are only re-decided at burst boundaries so
// fixed-length bursts and locked sequences are never split between masters.
module ahb_bus_arbiter #(
  parameter int unsigned NO_OF_MASTERS = 4,
  parameter int unsigned HMASTER_WIDTH = $clog2(NO_OF_MASTERS)
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [NO_OF_MASTERS-1:0] hbusreq,
  input  logic [NO_OF_MASTERS-1:0] hlock,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  input  logic                     hready,
  input  logic                     hresp,
  output logic [NO_OF_MASTERS-1:0] hgrant,
  output logic [HMASTER_WIDTH-1:0] hmaster,
  output logic                     hmastlock
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  typedef enum logic [1:0] {StArb, StBurst, StUndef} state_e;

  state_e                     state_q, state_d;
  logic [4:0]                 rem_q, rem_d;
  logic [HMASTER_WIDTH-1:0]   rr_last_q;
  logic [NO_OF_MASTERS-1:0]   hgrant_q;
  logic [HMASTER_WIDTH-1:0]   hmaster_q;
  logic                       hmastlock_q;

  logic [4:0]                 burst_len;
  logic                       restart;
  logic [HMASTER_WIDTH-1:0]   owner;
  logic                       arb_point;
  logic                       found;
  logic [HMASTER_WIDTH-1:0]   winner;
  logic [HMASTER_WIDTH:0]     cand_wide;
  logic [HMASTER_WIDTH-1:0]   cand;

  // Error responses end bursts only through the master's subsequent IDLE/NONSEQ.
  logic unused_hresp;
  assign unused_hresp = hresp;

  // Beat count per hburst; 0 marks an undefined-length INCR.
  always_comb begin
    unique case (hburst)
      3'b000:         burst_len = 5'd1;
      3'b001:         burst_len = 5'd0;
      3'b010, 3'b011: burst_len = 5'd4;
      3'b100, 3'b101: burst_len = 5'd8;
      3'b110, 3'b111: burst_len = 5'd16;
      default:        burst_len = 5'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    restart = 1'b0;
    case (state_q)
      StBurst: begin
        if (htrans == TransSeq) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) state_d = StArb;
        end else if (htrans != TransBusy) begin
          restart = 1'b1;
        end
      end
      StUndef: begin
        if (htrans == TransIdle) begin
          state_d = StArb;
        end else if (htrans == TransNonseq) begin
          restart = 1'b1;
        end
      end
      default: restart = 1'b1;
    endcase

    // Re-evaluate the current transfer as if no burst were in progress.
    if (restart) begin
      state_d = StArb;
      rem_d   = '0;
      if (htrans == TransNonseq) begin
        if (burst_len == 5'd0) begin
          state_d = StUndef;
        end else if (burst_len != 5'd1) begin
          state_d = StBurst;
          rem_d   = burst_len - 5'd1;
        end
      end
    end
  end

  always_comb begin
    owner = '0;
    for (int unsigned i = 0; i < NO_OF_MASTERS; i++) begin
      if (hgrant_q[i]) owner = HMASTER_WIDTH'(i);
    end
  end

  assign arb_point = (state_d == StArb) || ((state_d == StUndef) && !hbusreq[owner]);

  // Scan starts one past the last winner, so the previous winner is checked last.
  always_comb begin
    found     = 1'b0;
    winner    = rr_last_q;
    cand_wide = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NO_OF_MASTERS; k++) begin
      cand_wide = {1'b0, rr_last_q} + (HMASTER_WIDTH + 1)'(k);
      if (cand_wide >= (HMASTER_WIDTH + 1)'(NO_OF_MASTERS)) begin
        cand_wide = cand_wide - (HMASTER_WIDTH + 1)'(NO_OF_MASTERS);
      end
      cand = cand_wide[HMASTER_WIDTH-1:0];
      if (!found && hbusreq[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= StArb;
      rem_q       <= '0;
      rr_last_q   <= '0;
      hgrant_q    <= NO_OF_MASTERS'(1);
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
    end else if (hready) begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      hmaster_q   <= owner;
      hmastlock_q <= hlock[owner];
      if (arb_point && !hlock[owner] && found) begin
        hgrant_q  <= NO_OF_MASTERS'(1) << winner;
        rr_last_q <= winner;
      end
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level reference model.
module tb_ahb_bus_arbiter;

  localparam int N = 4;

  logic         hclk = 1'b0;
  logic         hresetn = 1'b0;
  logic [N-1:0] hbusreq = '0;
  logic [N-1:0] hlock = '0;
  logic [1:0]   htrans = 2'b00;
  logic [2:0]   hburst = 3'b000;
  logic         hready = 1'b1;
  logic         hresp = 1'b0;
  logic [N-1:0] hgrant;
  logic [1:0]   hmaster;
  logic         hmastlock;

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the grant, who won last, burst beats still owed.
  int m_grant, m_rr, m_master, m_lock, m_left;
  bit m_fixed, m_undef;

  ahb_bus_arbiter #(.NO_OF_MASTERS(N)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'd0: return 1;
      3'd1: return 0;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default: return 16;
    endcase
  endfunction

  task automatic model_reset();
    m_grant = 0; m_rr = 0; m_master = 0; m_lock = 0;
    m_left = 0; m_fixed = 0; m_undef = 0;
  endtask

  task automatic model_step();
    int owner;
    int len;
    bit cont;
    if (!hready) return;
    owner = m_grant;
    cont = (m_fixed || m_undef) && (htrans == 2'b11 || htrans == 2'b01);
    if (m_fixed && htrans == 2'b11) begin
      m_left = m_left - 1;
      if (m_left == 0) m_fixed = 0;
    end else if (m_undef && htrans == 2'b00) begin
      m_undef = 0;
    end else if (!cont) begin
      m_fixed = 0;
      m_undef = 0;
      m_left = 0;
      if (htrans == 2'b10) begin
        len = beats_of(hburst);
        if (len == 0) m_undef = 1;
        else if (len > 1) begin m_fixed = 1; m_left = len - 1; end
      end
    end
    if (!m_fixed && (!m_undef || !hbusreq[owner]) && !hlock[owner]) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (hbusreq[c]) begin
          m_grant = c;
          m_rr = c;
          break;
        end
      end
    end
    m_master = owner;
    m_lock = hlock[owner];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_hgrant", 32'(hgrant), 32'(1 << m_grant));
    check("model_hmaster", 32'(hmaster), 32'(m_master));
    check("model_hmastlock", 32'(hmastlock), 32'(m_lock));
    check("onehot_hgrant", 32'($onehot(hgrant)), 32'd1);
  endtask

  task automatic cycle();
    @(posedge hclk);
    if (hresetn) model_step();
    @(negedge hclk);
    compare_model();
  endtask

  task automatic set_in(input logic [N-1:0] req, input logic [N-1:0] lck, input logic [1:0] tr,
                        input logic [2:0] bu, input logic rdy, input logic rsp);
    hbusreq = req; hlock = lck; htrans = tr; hburst = bu; hready = rdy; hresp = rsp;
  endtask

  // Called at a falling edge; asserts reset mid-cycle and releases it at the next falling edge.
  task automatic async_reset(input bit literal);
    #2 hresetn = 1'b0;
    #1 model_reset();
    if (literal) begin
      check("rst_hgrant", 32'(hgrant), 32'h1);
      check("rst_hmaster", 32'(hmaster), 32'h0);
      check("rst_hmastlock", 32'(hmastlock), 32'h0);
    end
    compare_model();
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  logic [N-1:0] rot_g [4];
  logic [1:0]   rot_m [4];

  initial begin
    rot_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rot_m = '{2'd0, 2'd1, 2'd2, 2'd3};
    model_reset();
    @(negedge hclk);
    hresetn = 1'b1;
    check("reset_hgrant", 32'(hgrant), 32'h1);
    check("reset_hmaster", 32'(hmaster), 32'h0);
    check("reset_hmastlock", 32'(hmastlock), 32'h0);

    // No requests: parked on master 0.
    set_in(4'b0000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    repeat (5) begin
      cycle();
      check("idle_hgrant", 32'(hgrant), 32'h1);
      check("idle_hmaster", 32'(hmaster), 32'h0);
    end

    // All requesting, SINGLE transfers: grant rotates every edge.
    set_in(4'b1111, 4'b0000, 2'b10, 3'b000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("rot_hgrant", 32'(hgrant), 32'(rot_g[i]));
      check("rot_hmaster", 32'(hmaster), 32'(rot_m[i]));
    end

    // Master 1 runs INCR8 with wait states and a BUSY beat; master 2 waits for the end.
    set_in(4'b0010, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    cycle();
    cycle();
    check("incr8_owner", 32'(hgrant), 32'h2);
    check("incr8_hmaster", 32'(hmaster), 32'h1);
    set_in(4'b0110, 4'b0000, 2'b10, 3'b101, 1'b1, 1'b0);
    cycle();
    htrans = 2'b11;
    cycle();
    cycle();
    hready = 1'b0;
    cycle();
    cycle();
    check("wait_hgrant", 32'(hgrant), 32'h2);
    check("wait_hmaster", 32'(hmaster), 32'h1);
    hready = 1'b1;
    htrans = 2'b01;
    cycle();
    htrans = 2'b11;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("incr8_hgrant", 32'(hgrant), (i < 4) ? 32'h2 : 32'h4);
    end

    // Master 3 WRAP4 aborted by IDLE after an ERROR; master 0 takes over.
    set_in(4'b1000, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    cycle();
    check("wrap4_owner", 32'(hgrant), 32'h8);
    set_in(4'b1001, 4'b0000, 2'b10, 3'b010, 1'b1, 1'b0);
    cycle();
    set_in(4'b1001, 4'b0000, 2'b11, 3'b010, 1'b1, 1'b1);
    cycle();
    check("wrap4_hold", 32'(hgrant), 32'h8);
    set_in(4'b1001, 4'b0000, 2'b00, 3'b010, 1'b1, 1'b0);
    cycle();
    check("abort_hgrant", 32'(hgrant), 32'h1);

    // Master 2 locked across two INCR4 bursts.
    set_in(4'b0100, 4'b0100, 2'b00, 3'b000, 1'b1, 1'b0);
    cycle();
    set_in(4'b1111, 4'b0100, 2'b00, 3'b000, 1'b1, 1'b0);
    cycle();
    for (int b = 0; b < 8; b++) begin
      set_in(4'b1111, 4'b0100, (b % 4 == 0) ? 2'b10 : 2'b11, 3'b011, 1'b1, 1'b0);
      cycle();
      check("lock_hgrant", 32'(hgrant), 32'h4);
      check("lock_hmastlock", 32'(hmastlock), 32'h1);
    end
    set_in(4'b1111, 4'b0000, 2'b00, 3'b000, 1'b1, 1'b0);
    cycle();
    check("unlock_hgrant", 32'(hgrant), 32'h8);

    // Reset in the middle of INCR16 with 9 beats left; state must restart in ARB.
    set_in(4'b1111, 4'b0000, 2'b10, 3'b111, 1'b1, 1'b0);
    cycle();
    htrans = 2'b11;
    repeat (6) cycle();
    async_reset(1'b1);
    set_in(4'b0100, 4'b0000, 2'b11, 3'b111, 1'b1, 1'b0);
    cycle();
    check("post_rst_hgrant", 32'(hgrant), 32'h4);

    // Randomized traffic, SEQ-heavy so bursts run to completion often.
    for (int n = 0; n < 3000; n++) begin
      int r;
      hbusreq = N'($urandom);
      for (int j = 0; j < N; j++) hlock[j] = ($urandom % 8) == 0;
      r = $urandom % 10;
      htrans = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r < 4) ? 2'b10 : 2'b11;
      hburst = 3'($urandom);
      hready = ($urandom % 5) != 0;
      hresp = ($urandom % 8) == 0;
      if (($urandom % 300) == 0) async_reset(1'b0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
